// File: rtl/rs422_pkg.sv
// Shared RS-422 framing definitions used by the receive and transmit channels.
// Holds the receiver state encoding, 8N1 line levels and the divisor floor.
package rs422_pkg;

  localparam int   RX_MIN_DIV       = 4;
  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Divisors below the floor leave too few cycles to centre the start-bit sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] baud);
    return (baud < 16'(RX_MIN_DIV)) ? 16'(RX_MIN_DIV) : baud;
  endfunction

endpackage

// File: rtl/rs422_byte_fifo.sv
// Synchronous byte FIFO with registered read data and a one-cycle read-valid flag.
// A push into a full FIFO only succeeds when a pop frees the head slot in the same cycle.
module rs422_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       empty_o,
  output logic       drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
      rd_valid_d = 1'b1;
    end
  end

  // Storage is left unreset so it maps onto block RAM; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/rs422_rx_channel.sv
// Per-port 8N1 receiver: synchroniser, bit-timing FSM and byte FIFO behind a
// ready/read/used handshake towards the collector arbiter.
module rs422_rx_channel
  import rs422_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic [15:0] i_baud,
  input  logic        i_read,
  output logic        o_ready,
  output logic        o_used,
  output logic [7:0]  o_D,
  output logic        o_frame_err,
  output logic        o_overflow
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_now;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q;
  logic        expire;
  logic        fifo_empty;
  logic        fifo_drop;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign div_now = clamp_div(i_baud);
  // Counter is reloaded with the full divisor and expires on its last count,
  // so consecutive samples sit exactly div cycles apart.
  assign expire  = (cnt_q <= 16'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_rx};
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q == UART_IDLE_LEVEL && rx_s == UART_START_LEVEL) begin
          state_d = RX_START;
          div_d   = div_now;
          cnt_d   = div_now >> 1;
        end
      end
      RX_START: begin
        if (expire) begin
          if (rx_s == UART_START_LEVEL) begin
            state_d   = RX_DATA;
            cnt_d     = div_q;
            bit_idx_d = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (expire) begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = div_q;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (expire) begin
          if (rx_s == UART_STOP_LEVEL) begin
            push_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= 16'd0;
      div_q       <= 16'(RX_MIN_DIV);
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= fifo_drop;
    end
  end

  // shift_q is stable during the push cycle: only DATA modifies it.
  rs422_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (push_q),
    .push_data_i(shift_q),
    .pop_i      (i_read),
    .rd_data_o  (o_D),
    .rd_valid_o (o_used),
    .empty_o    (fifo_empty),
    .drop_o     (fifo_drop)
  );

  assign o_ready     = ~fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_rs422_rx_channel.sv
// Directed bench for rs422_rx_channel: table of clean frames, then hand-written
// sequences for framing errors, overflow, full+read, baud change, reset and glitches.
module tb_rs422_rx_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] baud;
  logic        rd;
  logic        ready;
  logic        used;
  logic [7:0]  dout;
  logic        ferr;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  rs422_rx_channel #(
    .FIFO_DEPTH (16),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .i_baud     (baud),
    .i_read     (rd),
    .o_ready    (ready),
    .o_used     (used),
    .o_D        (dout),
    .o_frame_err(ferr),
    .o_overflow (ovf)
  );

  always @(negedge clk) begin
    if (ferr === 1'b1) fe_cnt++;
    if (ovf === 1'b1) ov_cnt++;
  end

  typedef struct {
    logic [15:0] baud;
    int          cyc;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; each bit is held for cyc clock cycles.
  task automatic send_byte(input logic [7:0] data, input int cyc, input logic stop);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (cyc) @(negedge clk);
    end
  endtask

  task automatic wait_ready(input int bound, input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, ready}, 32'd1);
  endtask

  task automatic do_read(output logic [7:0] data, output logic u);
    rd = 1'b1;
    @(negedge clk);
    u    = used;
    data = dout;
    rd   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] exp);
    logic [7:0] data;
    logic       u;
    do_read(data, u);
    check({name, "_used"}, {31'd0, u}, 32'd1);
    check(name, {24'd0, data}, {24'd0, exp});
    $display("[TB] read %s: got %02h expected %02h", name, data, exp);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] data;
    logic       u;
    int         fe0;
    int         ov0;

    vecs[0] = '{16'd16, 16, 8'hA5, 8'hA5};
    vecs[1] = '{16'd16, 16, 8'h00, 8'h00};
    vecs[2] = '{16'd16, 16, 8'hFF, 8'hFF};
    vecs[3] = '{16'd7,  7,  8'h3C, 8'h3C};
    vecs[4] = '{16'd4,  4,  8'h81, 8'h81};
    vecs[5] = '{16'd0,  4,  8'h5A, 8'h5A};
    vecs[6] = '{16'd2,  4,  8'h96, 8'h96};
    vecs[7] = '{16'd3,  4,  8'hC3, 8'hC3};

    rst  = 1'b1;
    rx   = 1'b1;
    rd   = 1'b0;
    baud = 16'd16;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_used",  {31'd0, used},  32'd0);
    check("rst_D",     {24'd0, dout},  32'd0);
    check("rst_ferr",  {31'd0, ferr},  32'd0);
    check("rst_ovf",   {31'd0, ovf},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean frames across divisors, including the clamped low settings.
    for (int i = 0; i < 8; i++) begin
      baud = vecs[i].baud;
      @(negedge clk);
      send_byte(vecs[i].data, vecs[i].cyc, 1'b1);
      wait_ready(64, "vec_ready");
      do_read(data, u);
      check("vec_used", {31'd0, u}, 32'd1);
      check("vec_data", {24'd0, data}, {24'd0, vecs[i].exp});
      check("vec_drained", {31'd0, ready}, 32'd0);
      $display("[TB] vec %0d baud %0d sent %02h got %02h", i, vecs[i].baud, vecs[i].data, data);
    end
    check("vec_no_ferr", fe_cnt, 0);

    // Framing error followed by a long break, then recovery.
    baud = 16'd16;
    fe0  = fe_cnt;
    @(negedge clk);
    send_byte(8'h0A, 16, 1'b0);
    repeat (40 * 16) @(negedge clk);
    check("ferr_once", fe_cnt - fe0, 1);
    check("ferr_no_push", {31'd0, ready}, 32'd0);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    send_byte(8'h55, 16, 1'b1);
    wait_ready(64, "ferr_recover_ready");
    read_check("ferr_recover", 8'h55);
    check("ferr_total", fe_cnt - fe0, 1);

    // Seventeen bytes without reading: only the last one is dropped.
    baud = 16'd8;
    ov0  = ov_cnt;
    @(negedge clk);
    for (int b = 0; b < 17; b++) begin
      send_byte(8'(b), 8, 1'b1);
    end
    repeat (20) @(negedge clk);
    check("ovf_once", ov_cnt - ov0, 1);
    for (int b = 0; b < 16; b++) begin
      read_check("ovf_order", 8'(b));
    end
    check("ovf_drained", {31'd0, ready}, 32'd0);

    // Full FIFO, pop lands in the same cycle as the push of 0x30.
    for (int b = 0; b < 16; b++) begin
      send_byte(8'(8'h20 + b), 8, 1'b1);
    end
    repeat (20) @(negedge clk);
    ov0 = ov_cnt;
    @(negedge clk);
    fork
      send_byte(8'h30, 8, 1'b1);
      begin
        repeat (79) @(negedge clk);
        do_read(data, u);
      end
    join
    check("full_rd_used", {31'd0, u}, 32'd1);
    check("full_rd_data", {24'd0, data}, 32'h20);
    repeat (20) @(negedge clk);
    check("full_rd_no_ovf", ov_cnt - ov0, 0);
    for (int b = 1; b < 17; b++) begin
      read_check("full_rd_order", 8'(8'h20 + b));
    end
    check("full_rd_drained", {31'd0, ready}, 32'd0);

    // Divisor change mid-frame only affects the next frame.
    baud = 16'd16;
    @(negedge clk);
    fork
      send_byte(8'hC3, 16, 1'b1);
      begin
        repeat (50) @(negedge clk);
        baud = 16'd32;
      end
    join
    wait_ready(64, "baudchg_ready");
    read_check("baudchg_old", 8'hC3);
    @(negedge clk);
    send_byte(8'h69, 32, 1'b1);
    wait_ready(64, "baudchg_new_ready");
    read_check("baudchg_new", 8'h69);

    // Reset during data bit 4 with three bytes buffered.
    baud = 16'd16;
    @(negedge clk);
    send_byte(8'h11, 16, 1'b1);
    send_byte(8'h22, 16, 1'b1);
    send_byte(8'h33, 16, 1'b1);
    repeat (8) @(negedge clk);
    check("prerst_ready", {31'd0, ready}, 32'd1);
    fork
      send_byte(8'hF0, 16, 1'b1);
      begin
        repeat (88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_D", {24'd0, dout}, 32'd0);
        check("midrst_used", {31'd0, used}, 32'd0);
      end
    join
    repeat (20) @(negedge clk);
    check("postrst_empty", {31'd0, ready}, 32'd0);
    send_byte(8'h3C, 16, 1'b1);
    wait_ready(64, "postrst_ready");
    read_check("postrst_byte", 8'h3C);
    check("postrst_alone", {31'd0, ready}, 32'd0);

    // Single-cycle glitch at the minimum divisor.
    baud = 16'd0;
    fe0  = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_push", {31'd0, ready}, 32'd0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);
    send_byte(8'hE7, 4, 1'b1);
    wait_ready(64, "glitch_after_ready");
    read_check("glitch_after", 8'hE7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
